// File: rtl/cross_clock_irrevocable_pkg.sv
// Shared defaults for the toggle-handshake transfer stage.
package cross_clock_irrevocable_pkg;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/cross_clock_irrevocable_if.sv
// Producer/consumer valid-ready streams of the transfer stage.
interface cross_clock_irrevocable_if
  import cross_clock_irrevocable_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             io_src_valid;
  logic             io_src_ready;
  logic [WIDTH-1:0] io_src_bits;
  logic             io_dst_valid;
  logic             io_dst_ready;
  logic [WIDTH-1:0] io_dst_bits;

  modport master (
    output io_src_valid, io_src_bits, io_dst_ready,
    input  io_src_ready, io_dst_valid, io_dst_bits
  );

  modport slave (
    input  io_src_valid, io_src_bits, io_dst_ready,
    output io_src_ready, io_dst_valid, io_dst_bits
  );
endinterface

// File: rtl/cross_clock_irrevocable_sync_chain.sv
// 1-bit flop shift chain, asynchronously cleared.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/cross_clock_irrevocable.sv
// Single-word irrevocable valid/ready stage using a two-phase req/ack toggle pair.
module cross_clock_irrevocable
  import cross_clock_irrevocable_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      clock,
  input  logic                      reset_n,
  cross_clock_irrevocable_if.slave  io
);
  logic             r_req;
  logic             r_ack;
  logic [WIDTH-1:0] r_hold;
  logic             w_req_sync;
  logic             w_ack_sync;
  logic             w_src_ready;
  logic             w_dst_valid;
  logic             w_src_fire;
  logic             w_dst_fire;

  sync_chain #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     (r_req),
    .o_q     (w_req_sync)
  );

  sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     (r_ack),
    .o_q     (w_ack_sync)
  );

  // Ready/valid are pure flop compares, so no combinational path crosses the stage.
  assign w_src_ready = (r_req == w_ack_sync);
  assign w_dst_valid = (w_req_sync != r_ack);
  assign w_src_fire  = io.io_src_valid & w_src_ready;
  assign w_dst_fire  = w_dst_valid & io.io_dst_ready;

  // The hold register only loads on accept, which cannot happen while a word is in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req  <= 1'b0;
      r_hold <= '0;
    end else if (w_src_fire) begin
      r_req  <= ~r_req;
      r_hold <= io.io_src_bits;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        r_ack <= 1'b0;
    else if (w_dst_fire) r_ack <= ~r_ack;
  end

  assign io.io_src_ready = w_src_ready;
  assign io.io_dst_valid = w_dst_valid;
  assign io.io_dst_bits  = r_hold;
endmodule

// File: tb/tb_cross_clock_irrevocable.sv
// Scoreboarded bench for the toggle-handshake stage at SYNC_STAGES 2 and 3.
module tb_cross_clock_irrevocable;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc;
  int   rx_cnt;
  logic [7:0] exp_q[$];

  cross_clock_irrevocable_if #(.WIDTH(8)) sif();
  cross_clock_irrevocable_if #(.WIDTH(8)) bif();

  cross_clock_irrevocable #(.WIDTH(8), .SYNC_STAGES(2)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (sif)
  );

  cross_clock_irrevocable #(.WIDTH(8), .SYNC_STAGES(3)) u_dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: a fire is decided at the coming edge, so inputs and flops are stable at negedge.
  always @(negedge clock) begin
    if (reset_n && sif.io_dst_valid && sif.io_dst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", int'(sif.io_dst_bits), -1);
      end else begin
        chk("sb_data", int'(sif.io_dst_bits), int'(exp_q.pop_front()));
        rx_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    checks = 0; errors = 0; cyc = 0; rx_cnt = 0;
    reset_n = 1'b0;
    sif.io_src_valid = 1'b0; sif.io_src_bits = '0; sif.io_dst_ready = 1'b0;
    bif.io_src_valid = 1'b0; bif.io_src_bits = '0; bif.io_dst_ready = 1'b0;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_src_ready", int'(sif.io_src_ready), 1);
      chk("rst_dst_valid", int'(sif.io_dst_valid), 0);
      chk("rst_dst_bits",  int'(sif.io_dst_bits),  0);
    end
    reset_n = 1'b1;
    tick();

    // Single transfer, consumer stalled
    sif.io_src_valid = 1'b1; sif.io_src_bits = 8'h01;
    exp_q.push_back(8'h01);
    tick();
    sif.io_src_valid = 1'b0; sif.io_src_bits = 8'hEE;
    chk("t1_src_ready_fall", int'(sif.io_src_ready), 0);
    chk("t1_dst_valid_t0",   int'(sif.io_dst_valid), 0);
    tick();
    chk("t1_dst_valid_t1",   int'(sif.io_dst_valid), 0);
    tick();
    chk("t1_dst_valid_t2",   int'(sif.io_dst_valid), 1);
    chk("t1_dst_bits",       int'(sif.io_dst_bits),  8'h01);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t1_hold_valid", int'(sif.io_dst_valid), 1);
      chk("t1_hold_bits",  int'(sif.io_dst_bits),  8'h01);
      chk("t1_hold_ready", int'(sif.io_src_ready), 0);
    end

    // One-cycle accept pulse
    sif.io_dst_ready = 1'b1;
    tick();
    sif.io_dst_ready = 1'b0;
    chk("acc_dst_valid_drop", int'(sif.io_dst_valid), 0);
    chk("acc_src_ready_k0",   int'(sif.io_src_ready), 0);
    tick();
    chk("acc_src_ready_k1",   int'(sif.io_src_ready), 0);
    tick();
    chk("acc_src_ready_k2",   int'(sif.io_src_ready), 1);
    chk("acc_rx_cnt",         rx_cnt, 1);

    // Second word with consumer always ready
    sif.io_dst_ready = 1'b1;
    sif.io_src_valid = 1'b1; sif.io_src_bits = 8'h02;
    exp_q.push_back(8'h02);
    tick();
    sif.io_src_valid = 1'b0;
    tick(); tick();
    chk("w2_dst_valid_first", int'(sif.io_dst_valid), 1);
    chk("w2_dst_bits",        int'(sif.io_dst_bits),  8'h02);
    tick();
    chk("w2_dst_valid_drop",  int'(sif.io_dst_valid), 0);
    chk("w2_rx_cnt",          rx_cnt, 2);
    chk("w2_queue_empty",     exp_q.size(), 0);

    // Back-to-back streaming 0x00..0x0F
    sif.io_src_valid = 1'b1;
    last = 0;
    for (int i = 0; i < 16; i++) begin
      sif.io_src_bits = 8'(i);
      n = 0;
      while (!sif.io_src_ready && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) chk("stream_ready_timeout", 0, 1);
      exp_q.push_back(8'(i));
      tick();
      if (i > 0) chk("stream_gap", cyc - last, 6);
      last = cyc;
    end
    sif.io_src_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_rx_cnt",  rx_cnt, 18);
    tick(); tick(); tick();

    // Reset while 0xA5 is being presented; the word is discarded
    sif.io_dst_ready = 1'b0;
    sif.io_src_valid = 1'b1; sif.io_src_bits = 8'hA5;
    tick();
    sif.io_src_valid = 1'b0;
    tick(); tick();
    chk("mf_dst_valid", int'(sif.io_dst_valid), 1);
    chk("mf_dst_bits",  int'(sif.io_dst_bits),  8'hA5);
    reset_n = 1'b0;
    #1;
    chk("mf_rst_dst_valid", int'(sif.io_dst_valid), 0);
    chk("mf_rst_src_ready", int'(sif.io_src_ready), 1);
    chk("mf_rst_dst_bits",  int'(sif.io_dst_bits),  0);
    tick(); tick();
    reset_n = 1'b1;
    sif.io_dst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mf_no_a5", int'(sif.io_dst_valid), 0);
    end
    chk("mf_rx_cnt", rx_cnt, 18);

    // SYNC_STAGES=3 single transfer
    bif.io_src_valid = 1'b1; bif.io_src_bits = 8'h3C;
    tick();
    bif.io_src_valid = 1'b0;
    chk("s3_src_ready_fall", int'(bif.io_src_ready), 0);
    chk("s3_dst_valid_t0",   int'(bif.io_dst_valid), 0);
    tick();
    chk("s3_dst_valid_t1",   int'(bif.io_dst_valid), 0);
    tick();
    chk("s3_dst_valid_t2",   int'(bif.io_dst_valid), 0);
    tick();
    chk("s3_dst_valid_t3",   int'(bif.io_dst_valid), 1);
    chk("s3_dst_bits",       int'(bif.io_dst_bits),  8'h3C);
    bif.io_dst_ready = 1'b1;
    tick();
    bif.io_dst_ready = 1'b0;
    chk("s3_dst_valid_drop", int'(bif.io_dst_valid), 0);
    chk("s3_src_ready_k0",   int'(bif.io_src_ready), 0);
    tick();
    chk("s3_src_ready_k1",   int'(bif.io_src_ready), 0);
    tick();
    chk("s3_src_ready_k2",   int'(bif.io_src_ready), 0);
    tick();
    chk("s3_src_ready_k3",   int'(bif.io_src_ready), 1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
